// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pattern generator.
//   - vga_mode_e : pattern selector encodings
//   - DEF_*      : default 640x480@60 timing constants
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_GRAD  = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_SOLID = 2'd3
  } vga_mode_e;

  localparam int DEF_H_RES  = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;
  localparam int DEF_V_RES  = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Video output bundle of the pattern generator.
//   master : driven by vga_pattern_gen (sync, DE, coordinates, strobes, colour, frame count)
//   slave  : consumed by the encoder / DAC side
interface vga_pattern_gen_if #(
  parameter int X_W     = 10,
  parameter int Y_W     = 10,
  parameter int COLOR_W = 8,
  parameter int FRAME_W = 16
);
  logic               hsync;
  logic               vsync;
  logic               de;
  logic [X_W-1:0]     pixel_x;
  logic [Y_W-1:0]     pixel_y;
  logic               line_start;
  logic               frame_start;
  logic [COLOR_W-1:0] rgb_r;
  logic [COLOR_W-1:0] rgb_g;
  logic [COLOR_W-1:0] rgb_b;
  logic [FRAME_W-1:0] frame_cnt;

  modport master (output hsync, vsync, de, pixel_x, pixel_y, line_start, frame_start,
                  rgb_r, rgb_g, rgb_b, frame_cnt);
  modport slave  (input  hsync, vsync, de, pixel_x, pixel_y, line_start, frame_start,
                  rgb_r, rgb_g, rgb_b, frame_cnt);
endinterface

// File: rtl/vga_timing_core.sv
// Horizontal/vertical counters, frame counter and the first pipeline stage
// (sync/DE/coordinate/strobe decode registered from the counters).
//   clk, rst_n     : pixel clock, async active-low reset
//   pix_en_i       : advance enable
//   frame_top_o    : counters sit at h=0,v=0 (frame boundary, combinational)
//   *1_o           : stage-1 registered decode, one enabled cycle behind the counters
module vga_timing_core #(
  parameter int H_RES   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_RES   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter bit HS_POL  = 1'b0,
  parameter bit VS_POL  = 1'b0,
  parameter int FRAME_W = 16,
  parameter int X_W     = $clog2(H_RES + H_FP + H_SYNC + H_BP),
  parameter int Y_W     = $clog2(V_RES + V_FP + V_SYNC + V_BP)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_en_i,
  output logic               frame_top_o,
  output logic               de1_o,
  output logic               hs1_o,
  output logic               vs1_o,
  output logic [X_W-1:0]     x1_o,
  output logic [Y_W-1:0]     y1_o,
  output logic               ls1_o,
  output logic               fs1_o,
  output logic [FRAME_W-1:0] frm1_o
);
  localparam int H_TOTAL  = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_RES + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_RES + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_RES + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  logic [X_W-1:0]     h_q, h_d;
  logic [Y_W-1:0]     v_q, v_d;
  logic [FRAME_W-1:0] frm_q, frm_d;
  logic               de_c, hs_act, vs_act;

  always_comb begin
    h_d   = h_q;
    v_d   = v_q;
    frm_d = frm_q;
    if (pix_en_i) begin
      if (int'(h_q) == H_TOTAL - 1) begin
        h_d = '0;
        if (int'(v_q) == V_TOTAL - 1) begin
          v_d   = '0;
          frm_d = frm_q + 1'b1;
        end else begin
          v_d = v_q + 1'b1;
        end
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  // Compare in int so thresholds equal to the total never overflow X_W/Y_W.
  assign de_c        = (int'(h_q) < H_RES) && (int'(v_q) < V_RES);
  assign hs_act      = (int'(h_q) >= HS_START) && (int'(h_q) < HS_END);
  assign vs_act      = (int'(v_q) >= VS_START) && (int'(v_q) < VS_END);
  assign frame_top_o = (h_q == '0) && (v_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q    <= '0;
      v_q    <= '0;
      frm_q  <= '0;
      de1_o  <= 1'b0;
      hs1_o  <= ~HS_POL;
      vs1_o  <= ~VS_POL;
      x1_o   <= '0;
      y1_o   <= '0;
      ls1_o  <= 1'b0;
      fs1_o  <= 1'b0;
      frm1_o <= '0;
    end else begin
      h_q   <= h_d;
      v_q   <= v_d;
      frm_q <= frm_d;
      // Stage 1: decode of the current counter state
      if (pix_en_i) begin
        de1_o  <= de_c;
        hs1_o  <= hs_act ? HS_POL : ~HS_POL;
        vs1_o  <= vs_act ? VS_POL : ~VS_POL;
        x1_o   <= de_c ? h_q : '0;
        y1_o   <= de_c ? v_q : '0;
        ls1_o  <= (h_q == '0);
        fs1_o  <= frame_top_o;
        frm1_o <= frm_q;
      end
    end
  end
endmodule

// File: rtl/vga_pattern_gen.sv
// VGA timing master and test-pattern source.
//   clk, rst_n : pixel clock, async active-low reset
//   pix_en     : pixel clock enable, everything holds while low
//   mode       : pattern select, latched at the frame boundary
//   solid_rgb  : {r,g,b} for the solid pattern, sampled every enabled cycle
//   vid        : video output bundle (sync, DE, x/y, strobes, colour, frame count)
// Outputs are two enabled cycles behind the counters and mutually aligned.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_RES    = DEF_H_RES,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_RES    = DEF_V_RES,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int COLOR_W  = 8,
  parameter int CHK_LOG2 = 5,
  parameter int FRAME_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pix_en,
  input  logic [1:0]             mode,
  input  logic [3*COLOR_W-1:0]   solid_rgb,
  vga_pattern_gen_if.master      vid
);
  localparam int X_W = $clog2(H_RES + H_FP + H_SYNC + H_BP);
  localparam int Y_W = $clog2(V_RES + V_FP + V_SYNC + V_BP);
  localparam int CX  = (CHK_LOG2 < X_W) ? CHK_LOG2 : 0;
  localparam int CY  = (CHK_LOG2 < Y_W) ? CHK_LOG2 : 0;

  logic               frame_top, de1, hs1, vs1, ls1, fs1;
  logic [X_W-1:0]     x1;
  logic [Y_W-1:0]     y1;
  logic [FRAME_W-1:0] frm1;
  vga_mode_e          mode_q;
  logic [COLOR_W-1:0] r_d, g_d, b_d, xg, yg;
  logic [2:0]         bar_c;
  logic               chk_on;

  logic               de2_q, hs2_q, vs2_q, ls2_q, fs2_q;
  logic [X_W-1:0]     x2_q;
  logic [Y_W-1:0]     y2_q;
  logic [FRAME_W-1:0] frm2_q;
  logic [COLOR_W-1:0] r2_q, g2_q, b2_q;

  vga_timing_core #(
    .H_RES(H_RES), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_RES(V_RES), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .FRAME_W(FRAME_W), .X_W(X_W), .Y_W(Y_W)
  ) u_core (
    .clk(clk), .rst_n(rst_n), .pix_en_i(pix_en), .frame_top_o(frame_top),
    .de1_o(de1), .hs1_o(hs1), .vs1_o(vs1), .x1_o(x1), .y1_o(y1),
    .ls1_o(ls1), .fs1_o(fs1), .frm1_o(frm1)
  );

  // Bar index = number of fixed thresholds i*H_RES/8 already passed.
  function automatic logic [2:0] bar_idx(input logic [X_W-1:0] x);
    logic [2:0] k;
    k = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (int'(x) >= (i * H_RES) / 8) k = k + 3'd1;
    end
    return k;
  endfunction

  always_comb begin
    r_d    = '0;
    g_d    = '0;
    b_d    = '0;
    xg     = COLOR_W'(x1);
    yg     = COLOR_W'(y1);
    bar_c  = 3'd7 - bar_idx(x1);
    chk_on = ((CHK_LOG2 < X_W) && x1[CX]) ^ ((CHK_LOG2 < Y_W) && y1[CY]);
    if (de1) begin
      unique case (mode_q)
        MODE_GRAD: begin
          r_d = xg;
          g_d = yg;
          b_d = xg + yg;
        end
        MODE_BARS: begin
          r_d = {COLOR_W{bar_c[2]}};
          g_d = {COLOR_W{bar_c[1]}};
          b_d = {COLOR_W{bar_c[0]}};
        end
        MODE_CHECK: begin
          r_d = {COLOR_W{chk_on}};
          g_d = {COLOR_W{chk_on}};
          b_d = {COLOR_W{chk_on}};
        end
        MODE_SOLID: begin
          r_d = solid_rgb[3*COLOR_W-1 -: COLOR_W];
          g_d = solid_rgb[2*COLOR_W-1 -: COLOR_W];
          b_d = solid_rgb[COLOR_W-1:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_GRAD;
      de2_q  <= 1'b0;
      hs2_q  <= ~HS_POL;
      vs2_q  <= ~VS_POL;
      ls2_q  <= 1'b0;
      fs2_q  <= 1'b0;
      x2_q   <= '0;
      y2_q   <= '0;
      frm2_q <= '0;
      r2_q   <= '0;
      g2_q   <= '0;
      b2_q   <= '0;
    end else if (pix_en) begin
      // Latched together with stage 1 capturing pixel (0,0), so the new
      // pattern starts exactly at the first pixel of the next frame.
      if (frame_top) mode_q <= vga_mode_e'(mode);
      // Stage 2: colour plus delayed timing
      de2_q  <= de1;
      hs2_q  <= hs1;
      vs2_q  <= vs1;
      ls2_q  <= ls1;
      fs2_q  <= fs1;
      x2_q   <= x1;
      y2_q   <= y1;
      frm2_q <= frm1;
      r2_q   <= r_d;
      g2_q   <= g_d;
      b2_q   <= b_d;
    end
  end

  assign vid.hsync       = hs2_q;
  assign vid.vsync       = vs2_q;
  assign vid.de          = de2_q;
  assign vid.pixel_x     = x2_q;
  assign vid.pixel_y     = y2_q;
  assign vid.line_start  = ls2_q;
  assign vid.frame_start = fs2_q;
  assign vid.rgb_r       = r2_q;
  assign vid.rgb_g       = g2_q;
  assign vid.rgb_b       = b2_q;
  assign vid.frame_cnt   = frm2_q;
endmodule
